bist_responder: RTL and testbench

BIST_RESPONDER -- requirements
Module: bist_responder

---
 rtl/bist_responder.sv | 156 +++++++++++++++
 tb/tb_bist_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_responder.sv
// ---------------------------------------------------------------------------
// bist_responder
//
// Drives a fixed number of LFSR-generated bytes out over a mode-0 SPI
// link (sclk = clk/2, MSB first) and compares each byte that comes back
// on spi_miso with the byte that was sent. The run result is a pass flag
// and a saturating count of mismatching patterns.
//
// Parameters
//   NUM_PATTERNS  patterns per run, 1..255
//   SEED          nonzero LFSR value loaded when a run starts
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start_test  run request, level-sampled only while idle
//   spi_cs_n    chip select, low from the first LOAD through the last NEXT
//   spi_sclk    SPI clock, toggles only while shifting
//   spi_mosi    serial pattern out, MSB first
//   spi_miso    serial data back from the loopback path
//   test_busy   high while a run is in progress
//   test_done   one-cycle completion pulse
//   test_pass   result of the last completed run
//   fail_count  mismatching patterns, saturates at 15
// ---------------------------------------------------------------------------
module bist_responder #(
    parameter int unsigned NUM_PATTERNS = 8,
    parameter logic [7:0]  SEED         = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_test,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       test_busy,
    output logic       test_done,
    output logic       test_pass,
    output logic [3:0] fail_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        COMPARE = 3'd3,
        NEXT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [7:0] LAST_PATTERN = 8'(NUM_PATTERNS - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] lfsr;
    logic [7:0] tx_shreg;
    logic [7:0] rx_shreg;
    logic [2:0] bit_cnt;
    logic       phase;
    logic [7:0] pattern_cnt;

    // x^8+x^6+x^5+x^4+1, Fibonacci form: taps b7,b5,b4,b3 feed b0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case keeps every path
        // driven, so no latch is inferred for next_state.
        next_state = state;
        case (state)
            IDLE:    if (start_test) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (phase && bit_cnt == 3'd7) next_state = COMPARE;
            COMPARE: next_state = NEXT;
            NEXT:    next_state = (pattern_cnt == LAST_PATTERN) ? DONE : LOAD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the reset branch clears every register, including the
        // shift registers, so an aborted run leaves no residue behind.
        if (reset) begin
            state       <= IDLE;
            lfsr        <= '0;
            tx_shreg    <= '0;
            rx_shreg    <= '0;
            bit_cnt     <= '0;
            phase       <= 1'b0;
            pattern_cnt <= '0;
            fail_count  <= '0;
            test_pass   <= 1'b0;
            spi_cs_n    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every register here see
            // the pre-edge values of the others, independent of order.
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start_test) begin
                        lfsr        <= SEED;
                        pattern_cnt <= '0;
                        fail_count  <= '0;
                        test_pass   <= 1'b0;
                    end
                end
                LOAD: begin
                    tx_shreg <= lfsr;
                    bit_cnt  <= '0;
                    phase    <= 1'b0;
                    spi_cs_n <= 1'b0;
                end
                SHIFT: begin
                    phase <= ~phase;
                    // Sample on the high half of sclk; the next bit is
                    // presented on mosi as sclk falls.
                    if (phase) begin
                        rx_shreg <= {rx_shreg[6:0], spi_miso};
                        tx_shreg <= {tx_shreg[6:0], 1'b0};
                        bit_cnt  <= bit_cnt + 3'd1;
                    end
                end
                COMPARE: begin
                    if (rx_shreg != lfsr && fail_count != 4'hF)
                        fail_count <= fail_count + 4'd1;
                end
                NEXT: begin
                    lfsr        <= lfsr_step(lfsr);
                    pattern_cnt <= pattern_cnt + 8'd1;
                    if (pattern_cnt == LAST_PATTERN)
                        spi_cs_n <= 1'b1;
                end
                DONE: test_pass <= (fail_count == 4'd0);
                default: spi_cs_n <= 1'b1;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs decoded from state; sclk and mosi are quiet outside SHIFT.
    // -----------------------------------------------------------------------
    assign spi_sclk  = (state == SHIFT) && phase;
    assign spi_mosi  = (state == SHIFT) && tx_shreg[7];
    assign test_busy = (state != IDLE) && (state != DONE);
    assign test_done = (state == DONE);

endmodule

// File: tb/tb_bist_responder.sv
// ---------------------------------------------------------------------------
// tb_bist_responder
//
// Stimulus pushes the expected outcome of each run (completion edge, fail
// count, pass flag) and the expected byte sequence into queues; a monitor
// on the falling clock edge pops and compares whenever the DUT finishes a
// byte on SPI or pulses test_done.
// ---------------------------------------------------------------------------
module tb_bist_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_test;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       test_busy;
    logic       test_done;
    logic       test_pass;
    logic [3:0] fail_count;

    bist_responder #(.NUM_PATTERNS(8), .SEED(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_test (start_test),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .test_busy  (test_busy),
        .test_done  (test_done),
        .test_pass  (test_pass),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    // Hand-stepped LFSR sequence from seed A5.
    localparam logic [7:0] PATS [8] = '{8'hA5, 8'h4A, 8'h95, 8'h2A,
                                        8'h54, 8'hA9, 8'h53, 8'hA7};

    typedef struct {
        int         done_edge;
        logic [3:0] fails;
        logic       pass;
    } run_exp_t;

    run_exp_t   run_q[$];
    logic [7:0] byte_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // 0: loopback, 1: miso tied low, 2: loopback with pattern 3 inverted
    int miso_mode = 0;
    int nbits     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    assign spi_miso = (miso_mode == 0) ? spi_mosi :
                      (miso_mode == 1) ? 1'b0 :
                      (spi_mosi ^ (nbits > 0 && ((nbits - 1) / 8) == 3));

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_run(input int done_edge, input logic [3:0] fails,
                            input logic pass);
        run_exp_t r;
        r.done_edge = done_edge;
        r.fails     = fails;
        r.pass      = pass;
        run_q.push_back(r);
        for (int i = 0; i < 8; i++) byte_q.push_back(PATS[i]);
    endtask

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    logic [7:0] rx_byte   = '0;
    logic       lo_bit    = 1'b0;
    int         cs_low    = 0;
    logic       pend_pass = 1'b0;
    logic       exp_pass  = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            nbits     = 0;
            cs_low    = 0;
            pend_pass = 1'b0;
        end else begin
            if (pend_pass) begin
                check("test_pass_after_done", test_pass, exp_pass);
                pend_pass = 1'b0;
            end
            if (spi_cs_n) begin
                nbits = 0;
                check("idle_sclk_mosi", {spi_sclk, spi_mosi}, 2'b00);
            end else begin
                cs_low++;
                if (spi_sclk) begin
                    check("mosi_hold", spi_mosi, lo_bit);
                    rx_byte = {rx_byte[6:0], spi_mosi};
                    nbits++;
                    if (nbits % 8 == 0) begin
                        if (byte_q.size() == 0)
                            check("unexpected_byte", 1, 0);
                        else
                            check("mosi_byte", rx_byte, byte_q.pop_front());
                    end
                end else begin
                    lo_bit = spi_mosi;
                end
            end
            if (test_done) begin
                if (run_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    run_exp_t r;
                    r = run_q.pop_front();
                    check("done_edge", cyc, r.done_edge);
                    check("fail_count", fail_count, r.fails);
                    check("cs_low_cycles", cs_low, 151);
                    exp_pass  = r.pass;
                    pend_pass = 1'b1;
                end
                cs_low = 0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus (always driven right after a falling edge)
    // ---------------------------------------------------------------------
    task automatic wait_runs(input int budget);
        int t = 0;
        while ((run_q.size() != 0 || pend_pass) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("run_timeout", run_q.size(), 0);
        run_q.delete();
        byte_q.delete();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, spi_cs_n, 1'b1);
        check({tag, "_sclk_mosi"}, {spi_sclk, spi_mosi}, 2'b00);
        check({tag, "_busy_done"}, {test_busy, test_done}, 2'b00);
        check({tag, "_pass_fails"}, {test_pass, fail_count}, 5'h00);
    endtask

    // Pulse start once; returns the edge that sampled it.
    task automatic pulse_start(output int s);
        start_test = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start_test = 1'b0;
        check("busy_after_start", test_busy, 1'b1);
    endtask

    int s;

    initial begin
        reset      = 1'b1;
        start_test = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Loopback: all patterns match.
        miso_mode = 0;
        push_run(cyc + 1 + 152, 4'd0, 1'b1);
        pulse_start(s);
        wait_runs(400);

        // miso tied low: every pattern mismatches.
        miso_mode = 1;
        push_run(cyc + 1 + 152, 4'd8, 1'b0);
        pulse_start(s);
        wait_runs(400);

        // Pattern 3 comes back inverted: exactly one mismatch.
        miso_mode = 2;
        push_run(cyc + 1 + 152, 4'd1, 1'b0);
        pulse_start(s);
        wait_runs(400);

        // Controller-style pulses every 3 cycles: one run per IDLE entry.
        miso_mode = 0;
        s = cyc + 1;
        push_run(s + 152, 4'd0, 1'b1);
        push_run(s + 156 + 152, 4'd0, 1'b1);
        for (int i = 0; i < 57; i++) begin
            start_test = 1'b1;
            @(negedge clk);
            start_test = 1'b0;
            repeat (2) @(negedge clk);
        end
        wait_runs(400);

        // start held high through DONE restarts on the following IDLE.
        s = cyc + 1;
        push_run(s + 152, 4'd0, 1'b1);
        push_run(s + 154 + 152, 4'd0, 1'b1);
        start_test = 1'b1;
        while (cyc < s + 154) @(negedge clk);
        start_test = 1'b0;
        check("busy_second_held_run", test_busy, 1'b1);
        wait_runs(400);

        // Reset during SHIFT bit 4 of pattern 1 of a failing run.
        miso_mode = 1;
        push_run(cyc + 1 + 152, 4'd8, 1'b0);
        pulse_start(s);
        while (cyc < s + 28) @(negedge clk);
        check("pre_abort_fail_count", fail_count, 4'd1);
        check("pre_abort_sclk_low", spi_sclk, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_q.delete();
        byte_q.delete();
        check_reset_outputs("abort");
        // Any test_done in this window is flagged as unexpected.
        repeat (200) @(negedge clk);

        // A fresh run after the abort completes normally.
        miso_mode = 0;
        push_run(cyc + 1 + 152, 4'd0, 1'b1);
        pulse_start(s);
        wait_runs(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
